fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage of the RV32I soft core. Holds the program counter and issues one instruction-memory read at a time. It presents each fetched word, with its PC, to the decode stage through a valid/ready handshake; decode feeds the word to the immediate generator and control decode. It accepts PC redirects for taken branches and jumps, and squashes any wrong-path fetch in flight.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  read strobe, one cycle per fetch.
- imem_addr  out  32  word-aligned read address, valid while imem_req=1.
- imem_rvalid  in  1  read data valid, one cycle per request, arrives 1+ cycles after imem_req.
- imem_rdata  in  32  instruction word, valid with imem_rvalid.
- redirect_valid  in  1  load new PC, one-cycle pulse from execute.
- redirect_pc  in  32  redirect target; bits [1:0] ignored and forced to 0.
- if_valid  out  1  if_instr/if_pc hold a valid instruction.
- if_instr  out  32  fetched instruction.
- if_pc  out  32  address of if_instr.
- id_ready  in  1  decode accepts the instruction when if_valid && id_ready.

## Operation
- State machine, states START, FETCH, WAIT, HOLD, DROP. Reset state is START.
- All outputs are registered except imem_req and imem_addr.
- imem_req = (state==FETCH). imem_addr = pc.
- At most one memory request is outstanding. The memory accepts every request unconditionally.
- START: no request. Next state is FETCH.
- FETCH: request issued at pc. Next state is WAIT.
- WAIT:
  - On imem_rvalid: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4, next state HOLD.
  - pc+4 is a 32-bit modular add: 32'hFFFF_FFFC wraps to 0.
- HOLD: on if_valid && id_ready, if_valid<=0 and next state is FETCH. Otherwise if_instr, if_pc and if_valid hold stable.
- Redirect (redirect_valid=1) has priority over all other events. It always loads pc<={redirect_pc[31:2],2'b00} and clears if_valid.
  - START or HOLD: next state FETCH. In HOLD, a simultaneous id_ready does not transfer; the held instruction is squashed.
  - FETCH: the old-address request still goes out this cycle. Next state DROP.
  - WAIT without imem_rvalid: next state DROP.
  - WAIT with imem_rvalid in the same cycle: the response is discarded, not captured. Next state FETCH.
  - DROP: pc is updated, state stays DROP.
- DROP: waits for the stale response. On imem_rvalid the data is discarded and the next state is FETCH. if_valid stays 0 throughout.
- Reset mid-operation:
  - All state returns to reset values immediately, on the asynchronous assert.
  - An in-flight memory response that arrives after reset release lands in START or FETCH. It is ignored because it is not in WAIT or DROP.
  - The memory is reset by the same rst_n.

## Timing
- Reset values:
  - pc=RESET_PC, state=START.
  - imem_req=0, imem_addr=RESET_PC.
  - if_valid=0, if_instr=32'h0000_0013 (NOP), if_pc=32'h0.
- First imem_req is in the second rising edge's cycle after rst_n deasserts: START lasts one cycle, then FETCH.
- With single-cycle memory (rvalid the cycle after req) and id_ready held at 1, throughput is one instruction per 3 cycles: FETCH, WAIT, HOLD.
- if_valid rises on the edge that samples imem_rvalid. It falls on the edge that samples id_ready=1 or redirect_valid=1.
- A redirect takes effect on the next edge.
- The first instruction from the redirect target appears at the earliest 3 cycles after the redirect pulse, or 3 cycles after the stale response is dropped.

## Test plan
- Reset with RESET_PC=32'h100, memory latency 1, id_ready=1 -> imem_addr sequence 100,104,108. Each if_pc matches its address. if_instr equals memory contents. if_valid pulses one cycle every 3.
- id_ready=0 for 10 cycles while if_valid=1 -> if_instr/if_pc stable, no further imem_req. Release -> transfer, then the next fetch at pc+4.
- Redirect to 32'h203 during WAIT, memory latency 4 -> stale data never shows on if_valid. The next imem_addr is 32'h200.
- Redirect in the same cycle as imem_rvalid in WAIT -> no if_valid. The next request is at the redirect target.
- Redirect in HOLD with id_ready=1 in the same cycle -> no transfer, if_valid=0 next cycle, fetch resumes at the target.
- pc=32'hFFFF_FFFC fetched -> the next imem_addr is 32'h0. Assert rst_n=0 mid-WAIT -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one imem read at a time and
// hands each word to decode over a valid/ready handshake, honouring redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        START,
        FETCH,
        WAIT,
        HOLD,
        DROP
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic        if_valid_next;
    logic [31:0] if_instr_next, if_pc_next;

    // Low target bits are architecturally ignored.
    logic unused_redirect_bits;
    assign unused_redirect_bits = ^redirect_pc[1:0];

    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        if_valid_next = if_valid;
        if_instr_next = if_instr;
        if_pc_next    = if_pc;

        if (redirect_valid) begin
            pc_next       = {redirect_pc[31:2], 2'b00};
            if_valid_next = 1'b0;
            unique case (state)
                START, HOLD: state_next = FETCH;
                FETCH:       state_next = DROP;
                WAIT:        state_next = imem_rvalid ? FETCH : DROP;
                DROP:        state_next = DROP;
                default:     state_next = START;
            endcase
        end else begin
            unique case (state)
                START: state_next = FETCH;
                FETCH: state_next = WAIT;
                WAIT: begin
                    if (imem_rvalid) begin
                        if_instr_next = imem_rdata;
                        if_pc_next    = pc;
                        if_valid_next = 1'b1;
                        pc_next       = pc + 32'd4;
                        state_next    = HOLD;
                    end
                end
                HOLD: begin
                    if (if_valid && id_ready) begin
                        if_valid_next = 1'b0;
                        state_next    = FETCH;
                    end
                end
                // The stale response of a squashed fetch is swallowed here.
                DROP: begin
                    if (imem_rvalid) state_next = FETCH;
                end
                default: state_next = START;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= START;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            if_valid <= 1'b0;
            if_instr <= NOP;
            if_pc    <= 32'h0000_0000;
        end else begin
            pc       <= pc_next;
            if_valid <= if_valid_next;
            if_instr <= if_instr_next;
            if_pc    <= if_pc_next;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a behavioural instruction memory with
// programmable latency, plus scoreboards for issued addresses and transfers.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } xfer_t;

    logic [31:0] addr_q[$];
    xfer_t       exp_q[$];

    int xfer_cnt  = 0;
    int req_cnt   = 0;
    int valid_cyc = 0;

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .id_ready      (id_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
    endfunction

    // Memory: latency 1 means rvalid in the cycle right after the request.
    int          mem_lat = 1;
    int          mem_cnt;
    logic [31:0] mem_raddr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_rvalid <= 1'b0;
            imem_rdata  <= 32'h0;
            mem_cnt     <= 0;
            mem_raddr   <= 32'h0;
        end else begin
            imem_rvalid <= 1'b0;
            if (imem_req) begin
                mem_raddr <= imem_addr;
                if (mem_lat == 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= mem_data(imem_addr);
                end else begin
                    mem_cnt <= mem_lat - 1;
                end
            end else if (mem_cnt != 0) begin
                mem_cnt <= mem_cnt - 1;
                if (mem_cnt == 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= mem_data(mem_raddr);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs are stable at the falling edge, so requests and transfers are
    // scored exactly as the next rising edge will see them.
    always @(negedge clk) begin
        if (if_valid) valid_cyc++;
        if (imem_req) begin
            req_cnt++;
            if (addr_q.size() == 0) check("unexpected_req", imem_addr, 32'hxxxx_xxxx);
            else                    check("imem_addr", imem_addr, addr_q.pop_front());
        end
        if (if_valid && id_ready && !redirect_valid) begin
            xfer_t e;
            xfer_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_xfer", if_pc, 32'hxxxx_xxxx);
            end else begin
                e = exp_q.pop_front();
                check("xfer_pc", if_pc, e.pc);
                check("xfer_instr", if_instr, e.instr);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_q.push_back({pc, mem_data(pc)});
    endtask

    task automatic deliver();
        id_ready = 1'b1;
        tick(1);
        id_ready = 1'b0;
    endtask

    task automatic wait_valid(input int max, input string tag);
        int n = 0;
        while (!if_valid && n < max) begin
            tick(1);
            n++;
        end
        check(tag, {31'b0, if_valid}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   {31'b0, imem_req}, 32'd0);
        check({tag, "_addr"},  imem_addr, RST_PC);
        check({tag, "_valid"}, {31'b0, if_valid}, 32'd0);
        check({tag, "_instr"}, if_instr, NOP);
        check({tag, "_pc"},    if_pc, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held_pc, held_instr;
        int          req_snap;

        rst_n          = 1'b0;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        tick(2);
        check_reset_outputs("reset");

        // Back-to-back fetch with single-cycle memory and decode always ready.
        addr_q.push_back(32'h100); addr_q.push_back(32'h104); addr_q.push_back(32'h108);
        push_exp(32'h100); push_exp(32'h104); push_exp(32'h108);
        @(posedge clk); #1 rst_n = 1'b1;
        check("start_no_req", {31'b0, imem_req}, 32'd0);
        tick(9);
        check("cadence_xfers", xfer_cnt, 32'd2);
        check("cadence_valid_cycles", valid_cyc, 32'd2);
        check("third_pc", if_pc, 32'h108);

        // Decode stall: held word must stay put and no new request may issue.
        id_ready   = 1'b0;
        held_pc    = if_pc;
        held_instr = if_instr;
        req_snap   = req_cnt;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("stall_valid", {31'b0, if_valid}, 32'd1);
            check("stall_pc", if_pc, held_pc);
            check("stall_instr", if_instr, held_instr);
        end
        check("stall_no_req", req_cnt, req_snap);
        addr_q.push_back(32'h10C);
        deliver();
        check("post_stall_valid", {31'b0, if_valid}, 32'd0);
        wait_valid(20, "wait_10c");
        check("pc_10c", if_pc, 32'h10C);
        push_exp(32'h10C);
        deliver();

        // Redirect during WAIT with slow memory: stale word must never surface.
        mem_lat = 4;
        addr_q.push_back(32'h110);
        tick(1);
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        addr_q.push_back(32'h200);
        tick(1);
        redirect_valid = 1'b0;
        check("drop_valid", {31'b0, if_valid}, 32'd0);
        wait_valid(40, "wait_200");
        check("pc_200", if_pc, 32'h200);
        check("instr_200", if_instr, mem_data(32'h200));
        push_exp(32'h200);
        deliver();

        // Redirect coinciding with rvalid in WAIT: response discarded.
        mem_lat = 1;
        addr_q.push_back(32'h204);
        tick(1);
        check("rvalid_in_wait", {31'b0, imem_rvalid}, 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        addr_q.push_back(32'h300);
        tick(1);
        redirect_valid = 1'b0;
        check("wait_redirect_valid", {31'b0, if_valid}, 32'd0);
        check("wait_redirect_req", imem_addr, 32'h300);
        wait_valid(20, "wait_300");
        check("pc_300", if_pc, 32'h300);

        // Redirect in HOLD with id_ready: squash, no transfer.
        id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h400;
        addr_q.push_back(32'h400);
        tick(1);
        id_ready = 1'b0; redirect_valid = 1'b0;
        check("hold_redirect_valid", {31'b0, if_valid}, 32'd0);
        wait_valid(20, "wait_400");
        check("pc_400", if_pc, 32'h400);
        push_exp(32'h400);
        deliver();

        // Redirect in FETCH to the top word, then wrap to zero.
        addr_q.push_back(32'h404);
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        addr_q.push_back(32'hFFFF_FFFC);
        tick(1);
        redirect_valid = 1'b0;
        wait_valid(20, "wait_top");
        check("pc_top", if_pc, 32'hFFFF_FFFC);
        push_exp(32'hFFFF_FFFC);
        addr_q.push_back(32'h0);
        deliver();
        check("wrap_req", {31'b0, imem_req}, 32'd1);
        check("wrap_addr", imem_addr, 32'h0);

        // Asynchronous reset mid-WAIT, then clean restart.
        tick(1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        addr_q.push_back(RST_PC);
        @(posedge clk); #1 rst_n = 1'b1;
        wait_valid(20, "wait_restart");
        check("restart_pc", if_pc, RST_PC);
        check("restart_instr", if_instr, mem_data(RST_PC));

        check("addr_q_empty", addr_q.size(), 32'd0);
        check("exp_q_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
